// File: rtl/atomic_sequencer_if.sv
// Data-memory port used by the atomic sequencer while it owns the bus.
// The master drives the request side and the slave returns read data and the ack.
interface atomic_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/atomic_sequencer.sv
// RV32A execution unit: runs AMO read-modify-write sequences and LR/SC with a
// single-entry reservation on the data-memory port while the pipeline is stalled.
module atomic_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            funct5,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  misaligned,
    input  logic                  snoop_valid,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    atomic_sequencer_if.master    mem
);
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

    state_t                state_reg;
    logic [4:0]            funct_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic [DATA_WIDTH-1:0] old_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  misaligned_reg;
    logic                  req_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  res_valid_reg;
    logic [ADDR_WIDTH-1:0] res_addr_reg;
    logic [DATA_WIDTH-1:0] new_next;
    logic                  snoop_hit;
    logic                  own_write_hit;

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign result        = result_reg;
    assign misaligned    = misaligned_reg;
    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;

    // Reservations are tracked per word, so the byte offset is ignored.
    assign snoop_hit     = snoop_valid && (((snoop_addr ^ res_addr_reg) >> 2) == '0);
    assign own_write_hit = ((addr_reg ^ res_addr_reg) >> 2) == '0;

    always_comb begin
        new_next = operand_reg;
        case (funct_reg)
            F_ADD:   new_next = old_reg + operand_reg;
            F_XOR:   new_next = old_reg ^ operand_reg;
            F_AND:   new_next = old_reg & operand_reg;
            F_OR:    new_next = old_reg | operand_reg;
            F_MIN:   new_next = ($signed(old_reg) < $signed(operand_reg)) ? old_reg : operand_reg;
            F_MAX:   new_next = ($signed(old_reg) > $signed(operand_reg)) ? old_reg : operand_reg;
            F_MINU:  new_next = (old_reg < operand_reg) ? old_reg : operand_reg;
            F_MAXU:  new_next = (old_reg > operand_reg) ? old_reg : operand_reg;
            F_SWAP:  new_next = operand_reg;
            default: new_next = operand_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            funct_reg      <= '0;
            addr_reg       <= '0;
            operand_reg    <= '0;
            old_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            result_reg     <= '0;
            misaligned_reg <= 1'b0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_addr_reg   <= '0;
        end else begin
            // Snoop clear comes first so an LR completing this cycle overrides it.
            if (snoop_hit) res_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        funct_reg   <= funct5;
                        addr_reg    <= addr;
                        operand_reg <= operand;
                        busy_reg    <= 1'b1;
                        if (funct5 == F_SC) res_valid_reg <= 1'b0;
                        if (addr[1:0] != 2'b00) begin
                            misaligned_reg <= 1'b1;
                            result_reg     <= '0;
                            done_reg       <= 1'b1;
                            state_reg      <= DONE;
                        end else if (funct5 == F_SC) begin
                            if (res_valid_reg && (res_addr_reg == addr)) begin
                                req_reg   <= 1'b1;
                                we_reg    <= 1'b1;
                                wdata_reg <= operand;
                                state_reg <= WRITE;
                            end else begin
                                result_reg <= DATA_WIDTH'(1);
                                done_reg   <= 1'b1;
                                state_reg  <= DONE;
                            end
                        end else begin
                            req_reg   <= 1'b1;
                            we_reg    <= 1'b0;
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    if (mem.mem_ack) begin
                        old_reg <= mem.mem_rdata;
                        req_reg <= 1'b0;
                        if (funct_reg == F_LR) begin
                            res_valid_reg <= 1'b1;
                            res_addr_reg  <= addr_reg;
                            result_reg    <= mem.mem_rdata;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    wdata_reg <= new_next;
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b1;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        req_reg    <= 1'b0;
                        we_reg     <= 1'b0;
                        done_reg   <= 1'b1;
                        result_reg <= (funct_reg == F_SC) ? '0 : old_reg;
                        if (funct_reg != F_SC && own_write_hit) res_valid_reg <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg       <= 1'b0;
                    misaligned_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atomic_sequencer.sv
// Directed bench for atomic_sequencer: a table of single operations plus
// hand-written sequences for reservation, delayed-ack and reset corner cases.
module tb_atomic_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  funct5 = '0;
    logic [31:0] addr = '0;
    logic [31:0] operand = '0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;
    logic        busy, done, misaligned;
    logic [31:0] result;

    atomic_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mbus ();

    atomic_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct5(funct5), .addr(addr),
        .operand(operand), .busy(busy), .done(done), .result(result),
        .misaligned(misaligned), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .mem(mbus)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010;
    localparam logic [4:0] F_SC = 5'b00011, F_XOR = 5'b00100, F_OR = 5'b01000;
    localparam logic [4:0] F_AND = 5'b01100, F_MIN = 5'b10000, F_MAX = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000, F_MAXU = 5'b11100;

    // Memory model: acks after ack_delay wait cycles, checks request stability.
    logic [31:0] mem [logic [31:0]];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          unstable = 0;
    logic [31:0] held_addr, held_wdata;
    logic        held_we;

    initial begin
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            mbus.mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (mbus.mem_ack) begin
            mbus.mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (mbus.mem_req) begin
            req_cycles++;
            if (wait_cnt == 0) begin
                held_addr  = mbus.mem_addr;
                held_wdata = mbus.mem_wdata;
                held_we    = mbus.mem_we;
            end else if (held_addr != mbus.mem_addr || held_wdata != mbus.mem_wdata
                         || held_we != mbus.mem_we) begin
                unstable++;
            end
            if (wait_cnt == ack_delay) begin
                mbus.mem_ack   = 1'b1;
                mbus.mem_rdata = mem.exists(mbus.mem_addr) ? mem[mbus.mem_addr] : 32'h0;
                if (mbus.mem_we) mem[mbus.mem_addr] = mbus.mem_wdata;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge showing done.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] op,
                          output int lat, output logic [31:0] res, output logic mis);
        req_cycles = 0;
        start = 1'b1; funct5 = f; addr = a; operand = op;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check32("done_seen", {31'b0, done}, 32'd1);
        res = result;
        mis = misaligned;
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        check32({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [4:0]  f5;
        logic [31:0] addr;
        logic [31:0] operand;
        bit          preload;
        logic [31:0] init;
        logic [31:0] exp_res;
        logic        exp_mis;
        logic [31:0] exp_mem;
        int          exp_lat;
        int          exp_reqs;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string n, input logic [4:0] f, input logic [31:0] a,
                           input logic [31:0] op, input bit pl, input logic [31:0] init,
                           input logic [31:0] er, input logic em, input logic [31:0] emem,
                           input int el, input int ereq);
        vec_t v;
        v.name = n; v.f5 = f; v.addr = a; v.operand = op; v.preload = pl; v.init = init;
        v.exp_res = er; v.exp_mis = em; v.exp_mem = emem; v.exp_lat = el; v.exp_reqs = ereq;
        vq.push_back(v);
    endtask

    int          lat;
    logic [31:0] res;
    logic        mis;

    initial begin
        add_vec("amoadd",  F_ADD,  32'h100, 32'h1,        1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h80000000, 4, 2);
        add_vec("amomin",  F_MIN,  32'h104, 32'h1,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 4, 2);
        add_vec("amominu", F_MINU, 32'h108, 32'h1,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 4, 2);
        add_vec("amomax",  F_MAX,  32'h10C, 32'h1,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 4, 2);
        add_vec("amomaxu", F_MAXU, 32'h110, 32'h1,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 4, 2);
        add_vec("amoxor",  F_XOR,  32'h114, 32'hFF00FF00, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 32'hF00FF00F, 4, 2);
        add_vec("amoand",  F_AND,  32'h118, 32'hFF00FF00, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 32'h0F000F00, 4, 2);
        add_vec("amoor",   F_OR,   32'h11C, 32'hFF00FF00, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 32'hFF0FFF0F, 4, 2);
        add_vec("amoswap", F_SWAP, 32'h120, 32'hCAFEBABE, 1, 32'h12345678, 32'h12345678, 0, 32'hCAFEBABE, 4, 2);
        add_vec("undef",   5'b00101, 32'h124, 32'h2,      1, 32'h00000001, 32'h00000001, 0, 32'h00000002, 4, 2);
        add_vec("misalgn", F_SWAP, 32'h101, 32'h55,       1, 32'h0000DEAD, 32'h00000000, 1, 32'h0000DEAD, 1, 0);
        add_vec("sc_nores", F_SC,  32'h130, 32'h77,       1, 32'h00000033, 32'h00000001, 0, 32'h00000033, 1, 0);
        add_vec("lr",      F_LR,   32'h200, 32'h0,        1, 32'h00000011, 32'h00000011, 0, 32'h00000011, 2, 1);
        add_vec("sc_ok",   F_SC,   32'h200, 32'hA5,       0, 32'h0,        32'h00000000, 0, 32'h000000A5, 2, 1);
        add_vec("sc_again", F_SC,  32'h200, 32'h5A,       0, 32'h0,        32'h00000001, 0, 32'h000000A5, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_done", {31'b0, done}, 32'd0);
        check32("rst_req", {31'b0, mbus.mem_req}, 32'd0);
        check32("rst_result", result, 32'd0);
        check32("rst_mem_addr", mbus.mem_addr, 32'd0);

        foreach (vq[i]) begin
            if (vq[i].preload) mem[vq[i].addr] = vq[i].init;
            run_op(vq[i].f5, vq[i].addr, vq[i].operand, lat, res, mis);
            check32({vq[i].name, "_result"}, res, vq[i].exp_res);
            check32({vq[i].name, "_misaligned"}, {31'b0, mis}, {31'b0, vq[i].exp_mis});
            check32({vq[i].name, "_latency"}, lat, vq[i].exp_lat);
            check32({vq[i].name, "_req_cycles"}, req_cycles, vq[i].exp_reqs);
            finish_op(vq[i].name);
            check32({vq[i].name, "_mem"}, mem[vq[i].addr], vq[i].exp_mem);
            $display("vec %-9s addr=0x%08h result=0x%08h mis=%0d lat=%0d", vq[i].name,
                     vq[i].addr, res, mis, lat);
        end

        // LR, snoop to another byte of the same word, SC must fail.
        mem[32'h200] = 32'h22;
        run_op(F_LR, 32'h200, 32'h0, lat, res, mis);
        finish_op("snoop_lr");
        snoop_valid = 1'b1; snoop_addr = 32'h202;
        @(negedge clk);
        snoop_valid = 1'b0;
        run_op(F_SC, 32'h200, 32'h77, lat, res, mis);
        check32("snoop_sc_result", res, 32'd1);
        check32("snoop_sc_reqs", req_cycles, 32'd0);
        finish_op("snoop_sc");
        check32("snoop_sc_mem", mem[32'h200], 32'h22);
        $display("seq snoop: sc result=0x%08h", res);

        // Snoop coinciding with LR completion: the LR set takes priority.
        mem[32'h400] = 32'h44;
        snoop_valid = 1'b1; snoop_addr = 32'h400;
        run_op(F_LR, 32'h400, 32'h0, lat, res, mis);
        snoop_valid = 1'b0;
        finish_op("setwins_lr");
        run_op(F_SC, 32'h400, 32'h99, lat, res, mis);
        check32("setwins_sc_result", res, 32'd0);
        finish_op("setwins_sc");
        check32("setwins_sc_mem", mem[32'h400], 32'h99);
        $display("seq set-wins: sc result=0x%08h", res);

        // Own AMO write to the reserved word kills the reservation.
        mem[32'h800] = 32'h8;
        run_op(F_LR, 32'h800, 32'h0, lat, res, mis);
        finish_op("own_lr");
        run_op(F_ADD, 32'h800, 32'h1, lat, res, mis);
        finish_op("own_amo");
        run_op(F_SC, 32'h800, 32'h3, lat, res, mis);
        check32("own_sc_result", res, 32'd1);
        finish_op("own_sc");
        check32("own_sc_mem", mem[32'h800], 32'h9);
        $display("seq own-write: sc result=0x%08h", res);

        // Full AMO with two wait cycles on each access.
        ack_delay = 2; unstable = 0;
        mem[32'h900] = 32'h10;
        run_op(F_ADD, 32'h900, 32'h5, lat, res, mis);
        check32("delay_result", res, 32'h10);
        check32("delay_latency", lat, 32'd8);
        check32("delay_req_cycles", req_cycles, 32'd6);
        check32("delay_stable", unstable, 32'd0);
        finish_op("delay");
        check32("delay_mem", mem[32'h900], 32'h15);
        $display("seq delayed: result=0x%08h lat=%0d", res, lat);

        // Reserve 0x500, then reset in the middle of a delayed AMO write.
        ack_delay = 0;
        mem[32'h500] = 32'h50;
        run_op(F_LR, 32'h500, 32'h0, lat, res, mis);
        finish_op("rstseq_lr");
        ack_delay = 3; unstable = 0;
        mem[32'h600] = 32'h5;
        start = 1'b1; funct5 = F_ADD; addr = 32'h600; operand = 32'h1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!(mbus.mem_req && mbus.mem_we) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check32("rstseq_in_write", {31'b0, mbus.mem_we}, 32'd1);
        check32("rstseq_read_stable", unstable, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check32("rstseq_req", {31'b0, mbus.mem_req}, 32'd0);
        check32("rstseq_we", {31'b0, mbus.mem_we}, 32'd0);
        check32("rstseq_busy", {31'b0, busy}, 32'd0);
        check32("rstseq_done", {31'b0, done}, 32'd0);
        check32("rstseq_result", result, 32'd0);
        check32("rstseq_mem_addr", mbus.mem_addr, 32'd0);
        check32("rstseq_mem_wdata", mbus.mem_wdata, 32'd0);
        rst = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        check32("rstseq_mem_untouched", mem[32'h600], 32'h5);
        run_op(F_SC, 32'h500, 32'h1, lat, res, mis);
        check32("rstseq_sc_result", res, 32'd1);
        check32("rstseq_sc_latency", lat, 32'd1);
        finish_op("rstseq_sc");
        $display("seq reset: sc after reset result=0x%08h", res);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/atomic_sequencer.md
Name: atomic_sequencer

Overview:
- Multi-cycle controller that executes RV32A instructions (ATOMIC_OPCODE 7'b0101111) in the EX/MEM stage.
- Sequences read-modify-write on the data-memory port for AMO* instructions. Handles LR.W/SC.W with a single-entry reservation.
- The pipeline stalls while busy is high and takes result/rd on the done pulse.
- The core's data-bus mux gives this block the memory port while busy.

Parameters:
- ADDR_WIDTH, 32, width of the memory address.
- DATA_WIDTH, 32, data width; only 32 is supported (RV32).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from EX; sampled only in IDLE.
- funct5  in  5  instr[31:27] atomic operation select.
- addr  in  ADDR_WIDTH  rs1 value (effective address).
- operand  in  DATA_WIDTH  rs2 value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_WIDTH  rd writeback value, valid when done=1.
- misaligned  out  1  valid when done=1; addr[1:0]!=0, so no memory access was made.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_WIDTH  word address (latched addr).
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge; ignored when mem_req=0.
- snoop_valid  in  1  a store by another agent/path completed.
- snoop_addr  in  ADDR_WIDTH  address of that store.

Behaviour:
- Reset: state=IDLE. busy, done, misaligned, mem_req, mem_we = 0. result, mem_addr, mem_wdata = 0. Reservation invalid. Reset mid-transaction abandons the access immediately (mem_req=0 next cycle).
- Decoding funct5:
  - LR=00010, SC=00011
  - SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000
  - MIN=10000, MAX=10100, MINU=11000, MAXU=11100
  - Any other code acts as SWAP.
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE:
  - start=1 latches funct5, addr, operand.
  - If addr[1:0]!=0, go to DONE with misaligned=1 and result=0.
  - Else if SC, go to WRITE when the reservation is valid and its addr equals addr; otherwise go to DONE with result=1. The reservation is cleared in both cases.
  - Else go to READ.
- READ: mem_req=1, mem_we=0. On mem_ack, capture old=mem_rdata.
  - LR: set reservation {valid, addr}, then go to DONE.
  - Otherwise go to CALC.
- CALC (1 cycle): new = f(old, operand).
  - MIN/MAX compare signed 32-bit; MINU/MAXU compare unsigned.
  - ADD wraps modulo 2^32.
  - Go to WRITE.
- WRITE: mem_req=1, mem_we=1, mem_wdata = new (AMO) or operand (SC). On mem_ack go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - result = old for AMO/LR; result = 0 for a successful SC.
  - busy drops in the cycle after DONE.
- Latency with zero-wait ack (ack in the first req cycle):
  - AMO: start to done = 4 cycles.
  - LR: 2 cycles.
  - SC success: 2 cycles; SC fail: 1 cycle.
- mem_addr and mem_wdata are stable throughout a request. mem_req never drops before ack.
- Reservation clears on:
  - snoop_valid with snoop_addr[ADDR_WIDTH-1:2] equal to the reserved word;
  - any SC;
  - this block's own AMO write to the reserved word.
- Snoop and LR set in the same cycle: set wins.
- start while busy is ignored, with no queueing.

Test Plan:
- AMOADD: mem[0x100]=0x7FFFFFFF, operand=1, ack on first req cycle. Expect write 0x80000000, result=0x7FFFFFFF, done 4 cycles after start.
- AMOMIN/AMOMINU: old=0xFFFFFFFF, operand=1. Expect MIN writes 0xFFFFFFFF and MINU writes 0x00000001. Both return 0xFFFFFFFF.
- LR then SC to 0x200 with operand=0xA5: expect result 0 and write 0xA5. A second SC to 0x200: expect result=1 and no mem_req.
- LR 0x200, then snoop_valid at 0x202, then SC 0x200: expect result=1 and no write.
- Misaligned AMOSWAP at addr 0x101: expect done with misaligned=1, result=0, mem_req never asserted.
- Ack delayed 3 cycles in READ; rst asserted in WRITE. Expect mem_req held stable through the delay, then all outputs 0 and IDLE one cycle after rst.
